// File: rtl/arbitro_pkg.sv
// Shared definitions for the two-requester arbiter around the hello_world gate:
// FSM encoding and requester indices.
package arbitro_pkg;

  typedef enum logic [1:0] {
    LIBRE    = 2'd0,
    EVALUA   = 2'd1,
    RESPONDE = 2'd2
  } estado_t;

  localparam logic REQ_0 = 1'b0;
  localparam logic REQ_1 = 1'b1;

  // The other requester; round-robin hands priority to it after each service.
  function automatic logic otro(input logic k);
    return ~k;
  endfunction

endpackage

// File: rtl/hello_world.sv
// The shared combinational gate: F = (A | B) & B.
module hello_world (
  input  logic A,
  input  logic B,
  output logic F
);

  assign F = (A | B) & B;

endmodule

// File: rtl/arbitro_compuerta.sv
// Round-robin arbiter sharing one hello_world gate between two valid/ready requesters,
// with registered operands/result and a per-requester served-transaction counter.
module arbitro_compuerta
  import arbitro_pkg::*;
#(
  parameter int ANCHO_CONTADOR = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sol_valida_0,
  input  logic                      sol_valida_1,
  input  logic                      sol_A_0,
  input  logic                      sol_B_0,
  input  logic                      sol_A_1,
  input  logic                      sol_B_1,
  output logic                      sol_lista_0,
  output logic                      sol_lista_1,
  output logic                      resp_valida_0,
  output logic                      resp_valida_1,
  output logic                      resp_F_0,
  output logic                      resp_F_1,
  input  logic                      resp_lista_0,
  input  logic                      resp_lista_1,
  output logic [ANCHO_CONTADOR-1:0] servidas_0,
  output logic [ANCHO_CONTADOR-1:0] servidas_1
);

  estado_t                   estado_q, estado_d;
  logic                      prioridad_q, prioridad_d;
  logic                      concedido_q, concedido_d;
  logic                      op_a_q, op_a_d;
  logic                      op_b_q, op_b_d;
  logic                      resultado_q, resultado_d;
  logic [ANCHO_CONTADOR-1:0] servidas_0_q, servidas_0_d;
  logic [ANCHO_CONTADOR-1:0] servidas_1_q, servidas_1_d;

  logic puerta_f;
  logic hay_sol;
  logic ganador;
  logic resp_lista_sel;

  hello_world u_puerta (
    .A (op_a_q),
    .B (op_b_q),
    .F (puerta_f)
  );

  // Ties go to the priority register; a lone request wins outright.
  always_comb begin
    hay_sol = sol_valida_0 | sol_valida_1;
    if (sol_valida_0 && sol_valida_1) begin
      ganador = prioridad_q;
    end else if (sol_valida_1) begin
      ganador = REQ_1;
    end else begin
      ganador = REQ_0;
    end
    resp_lista_sel = (concedido_q == REQ_1) ? resp_lista_1 : resp_lista_0;
  end

  always_comb begin
    estado_d      = estado_q;
    prioridad_d   = prioridad_q;
    concedido_d   = concedido_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    resultado_d   = resultado_q;
    servidas_0_d  = servidas_0_q;
    servidas_1_d  = servidas_1_q;
    sol_lista_0   = 1'b0;
    sol_lista_1   = 1'b0;
    resp_valida_0 = 1'b0;
    resp_valida_1 = 1'b0;
    resp_F_0      = 1'b0;
    resp_F_1      = 1'b0;

    case (estado_q)
      LIBRE: begin
        if (hay_sol) begin
          sol_lista_0 = (ganador == REQ_0);
          sol_lista_1 = (ganador == REQ_1);
          op_a_d      = (ganador == REQ_1) ? sol_A_1 : sol_A_0;
          op_b_d      = (ganador == REQ_1) ? sol_B_1 : sol_B_0;
          concedido_d = ganador;
          estado_d    = EVALUA;
        end
      end

      EVALUA: begin
        resultado_d = puerta_f;
        estado_d    = RESPONDE;
      end

      RESPONDE: begin
        resp_valida_0 = (concedido_q == REQ_0);
        resp_valida_1 = (concedido_q == REQ_1);
        resp_F_0      = (concedido_q == REQ_0) & resultado_q;
        resp_F_1      = (concedido_q == REQ_1) & resultado_q;
        if (resp_lista_sel) begin
          // Counters wrap silently at 2^ANCHO_CONTADOR.
          if (concedido_q == REQ_1) begin
            servidas_1_d = servidas_1_q + ANCHO_CONTADOR'(1);
          end else begin
            servidas_0_d = servidas_0_q + ANCHO_CONTADOR'(1);
          end
          prioridad_d = otro(concedido_q);
          estado_d    = LIBRE;
        end
      end

      default: begin
        estado_d = LIBRE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q     <= LIBRE;
      prioridad_q  <= REQ_0;
      concedido_q  <= REQ_0;
      op_a_q       <= 1'b0;
      op_b_q       <= 1'b0;
      resultado_q  <= 1'b0;
      servidas_0_q <= '0;
      servidas_1_q <= '0;
    end else begin
      estado_q     <= estado_d;
      prioridad_q  <= prioridad_d;
      concedido_q  <= concedido_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      resultado_q  <= resultado_d;
      servidas_0_q <= servidas_0_d;
      servidas_1_q <= servidas_1_d;
    end
  end

  assign servidas_0 = servidas_0_q;
  assign servidas_1 = servidas_1_q;

endmodule

// File: tb/tb_arbitro_compuerta.sv
// Self-checking bench: two arbiters (8-bit and 2-bit counters) on shared stimulus, checked
// against a transaction-level model (round-robin winner, 2-cycle latency, F equals accepted B).
module tb_arbitro_compuerta;

  logic clk = 1'b0;
  logic rst;
  logic sv0, sv1, a0, b0, a1, b1, rl0, rl1;
  logic sl0, sl1, rv0, rv1, rf0, rf1;
  logic y_sl0, y_sl1, y_rv0, y_rv1, y_rf0, y_rf1;
  logic [7:0] s0, s1;
  logic [1:0] y_s0, y_s1;
  logic [5:0] obs_vec, obs2_vec;

  int checks = 0;
  int errors = 0;

  // Reference model state: is a transaction in flight, who owns it, cycles since
  // its handshake, who wins the next tie, and total completions per requester.
  bit   busy, owner, nxt_pri, exp_f;
  int   age, cnt0, cnt1;
  logic [5:0] exp_vec;
  int   exp_s0, exp_s1;

  always #5 clk = ~clk;

  arbitro_compuerta #(.ANCHO_CONTADOR(8)) dut (
    .clk(clk), .rst(rst),
    .sol_valida_0(sv0), .sol_valida_1(sv1),
    .sol_A_0(a0), .sol_B_0(b0), .sol_A_1(a1), .sol_B_1(b1),
    .sol_lista_0(sl0), .sol_lista_1(sl1),
    .resp_valida_0(rv0), .resp_valida_1(rv1),
    .resp_F_0(rf0), .resp_F_1(rf1),
    .resp_lista_0(rl0), .resp_lista_1(rl1),
    .servidas_0(s0), .servidas_1(s1)
  );

  arbitro_compuerta #(.ANCHO_CONTADOR(2)) dut2 (
    .clk(clk), .rst(rst),
    .sol_valida_0(sv0), .sol_valida_1(sv1),
    .sol_A_0(a0), .sol_B_0(b0), .sol_A_1(a1), .sol_B_1(b1),
    .sol_lista_0(y_sl0), .sol_lista_1(y_sl1),
    .resp_valida_0(y_rv0), .resp_valida_1(y_rv1),
    .resp_F_0(y_rf0), .resp_F_1(y_rf1),
    .resp_lista_0(rl0), .resp_lista_1(rl1),
    .servidas_0(y_s0), .servidas_1(y_s1)
  );

  assign obs_vec  = {sl0, sl1, rv0, rv1, rf0, rf1};
  assign obs2_vec = {y_sl0, y_sl1, y_rv0, y_rv1, y_rf0, y_rf1};

  task automatic model_reset();
    busy = 0; owner = 0; nxt_pri = 0; exp_f = 0; age = 0; cnt0 = 0; cnt1 = 0;
  endtask

  // Expected outputs for the current cycle's inputs, then advance one cycle.
  task automatic model_cycle();
    bit win;
    exp_vec = '0;
    exp_s0  = cnt0;
    exp_s1  = cnt1;
    if (!busy) begin
      if (sv0 || sv1) begin
        if (sv0 && sv1) win = nxt_pri;
        else            win = sv1;
        if (win) exp_vec[4] = 1'b1;
        else     exp_vec[5] = 1'b1;
        busy  = 1;
        owner = win;
        age   = 0;
        exp_f = win ? b1 : b0;
      end
    end else if (age >= 2) begin
      if (owner) begin exp_vec[2] = 1'b1; exp_vec[0] = exp_f; end
      else       begin exp_vec[3] = 1'b1; exp_vec[1] = exp_f; end
      if (owner ? rl1 : rl0) begin
        if (owner) cnt1++;
        else       cnt0++;
        nxt_pri = !owner;
        busy    = 0;
      end
    end
    if (busy) age++;
  endtask

  task automatic zero_inputs();
    sv0 = 0; sv1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; rl0 = 0; rl1 = 0;
  endtask

  task automatic apply_reset();
    zero_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    zero_inputs();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (obs_vec !== 6'b0 || obs2_vec !== 6'b0) begin
      errors++;
      $display("FAIL reset outputs got %b/%b want 000000", obs_vec, obs2_vec);
    end
    checks++;
    if (s0 !== 8'd0 || s1 !== 8'd0 || y_s0 !== 2'd0 || y_s1 !== 2'd0) begin
      errors++;
      $display("FAIL reset servidas got %0d,%0d/%0d,%0d want 0", s0, s1, y_s0, y_s1);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      sv0 = (c == 0); a0 = 1; b0 = 0; rl0 = 1; sv1 = 0; rl1 = 0;
      #1; model_cycle();
      checks++;
      if (obs_vec !== exp_vec || obs2_vec !== exp_vec) begin
        errors++; $display("FAIL single c%0d outputs got %b/%b want %b", c, obs_vec, obs2_vec, exp_vec);
      end
      checks++;
      if (s0 !== exp_s0[7:0] || s1 !== exp_s1[7:0] || y_s0 !== exp_s0[1:0] || y_s1 !== exp_s1[1:0]) begin
        errors++; $display("FAIL single c%0d servidas got %0d,%0d want %0d,%0d", c, s0, s1, exp_s0, exp_s1);
      end
      if (c == 0) begin
        checks++;
        if (sl0 !== 1'b1) begin errors++; $display("FAIL single_grant got %b want 1", sl0); end
      end
      if (c == 2) begin
        checks++;
        if (rv0 !== 1'b1 || rf0 !== 1'b0) begin
          errors++; $display("FAIL single_resp got v=%b f=%b want v=1 f=0", rv0, rf0);
        end
      end
      if (c == 3) begin
        checks++;
        if (s0 !== 8'd1) begin errors++; $display("FAIL single_count got %0d want 1", s0); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_both();
    bit done0, done1;
    bit order[$];
    apply_reset();
    done0 = 0; done1 = 0;
    for (int c = 0; c < 8; c++) begin
      sv0 = !done0; a0 = 0; b0 = 1; sv1 = !done1; a1 = 1; b1 = 1; rl0 = 1; rl1 = 1;
      #1; model_cycle();
      checks++;
      if (obs_vec !== exp_vec || obs2_vec !== exp_vec) begin
        errors++; $display("FAIL both c%0d outputs got %b/%b want %b", c, obs_vec, obs2_vec, exp_vec);
      end
      if (sl0) order.push_back(1'b0);
      if (sl1) order.push_back(1'b1);
      if (exp_vec[5]) done0 = 1;
      if (exp_vec[4]) done1 = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (order.size() != 2 || order[0] !== 1'b0 || order[1] !== 1'b1) begin
      errors++; $display("FAIL both_order got %0d grants want 0 then 1", order.size());
    end
    checks++;
    if (s0 !== 8'd1 || s1 !== 8'd1) begin
      errors++; $display("FAIL both_counts got %0d,%0d want 1,1", s0, s1);
    end
  endtask

  task automatic test_alternate();
    bit grants[$];
    apply_reset();
    a0 = 1'($urandom); b0 = 1'($urandom); a1 = 1'($urandom); b1 = 1'($urandom);
    for (int c = 0; c < 36; c++) begin
      sv0 = 1; sv1 = 1; rl0 = 1; rl1 = 1;
      #1; model_cycle();
      checks++;
      if (obs_vec !== exp_vec || obs2_vec !== exp_vec) begin
        errors++; $display("FAIL alternate c%0d outputs got %b/%b want %b", c, obs_vec, obs2_vec, exp_vec);
      end
      if (sl0) grants.push_back(1'b0);
      if (sl1) grants.push_back(1'b1);
      @(posedge clk); #1;
      if (exp_vec[5]) begin a0 = 1'($urandom); b0 = 1'($urandom); end
      if (exp_vec[4]) begin a1 = 1'($urandom); b1 = 1'($urandom); end
    end
    checks++;
    if (grants.size() != 12) begin
      errors++; $display("FAIL alternate_count got %0d grants want 12", grants.size());
    end
    for (int i = 0; i < grants.size(); i++) begin
      checks++;
      if (grants[i] !== 1'(i % 2)) begin
        errors++; $display("FAIL alternate_grant%0d got %b want %0d", i, grants[i], i % 2);
      end
    end
    checks++;
    if (s0 !== 8'd6 || s1 !== 8'd6) begin
      errors++; $display("FAIL alternate_counts got %0d,%0d want 6,6", s0, s1);
    end
  endtask

  task automatic test_backpressure();
    bit served0;
    apply_reset();
    served0 = 0;
    a0 = 1'($urandom); b0 = 1'($urandom); a1 = 1'($urandom); b1 = 1;
    for (int c = 0; c < 12; c++) begin
      sv1 = (c == 0); sv0 = (c >= 1 && c <= 8); rl1 = (c >= 7); rl0 = 1;
      #1; model_cycle();
      checks++;
      if (obs_vec !== exp_vec || obs2_vec !== exp_vec) begin
        errors++; $display("FAIL backpressure c%0d outputs got %b/%b want %b", c, obs_vec, obs2_vec, exp_vec);
      end
      if (c >= 2 && c <= 6) begin
        checks++;
        if (rv1 !== 1'b1 || rf1 !== 1'b1 || sl0 !== 1'b0) begin
          errors++; $display("FAIL backpressure_hold c%0d got v=%b f=%b lista0=%b want 1 1 0", c, rv1, rf1, sl0);
        end
      end
      if (sl0 && c >= 7) served0 = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (!served0 || s0 !== 8'd1 || s1 !== 8'd1) begin
      errors++; $display("FAIL backpressure_release got served0=%b counts %0d,%0d want 1,1,1", served0, s0, s1);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    a0 = 0; b0 = 1; a1 = 1; b1 = 1;
    for (int c = 0; c < 11; c++) begin
      sv0 = (c == 0) || (c == 10); sv1 = (c == 3) || (c == 10); rl0 = 1; rl1 = 1;
      rst = (c == 4);
      #1; model_cycle();
      checks++;
      if (obs_vec !== exp_vec || obs2_vec !== exp_vec) begin
        errors++; $display("FAIL reset_mid c%0d outputs got %b/%b want %b", c, obs_vec, obs2_vec, exp_vec);
      end
      checks++;
      if (s0 !== exp_s0[7:0] || s1 !== exp_s1[7:0] || y_s0 !== exp_s0[1:0] || y_s1 !== exp_s1[1:0]) begin
        errors++; $display("FAIL reset_mid c%0d servidas got %0d,%0d want %0d,%0d", c, s0, s1, exp_s0, exp_s1);
      end
      if (c == 10) begin
        checks++;
        if (sl0 !== 1'b1 || sl1 !== 1'b0) begin
          errors++; $display("FAIL reset_mid_priority got %b%b want 10", sl0, sl1);
        end
      end
      @(posedge clk); #1;
      if (c == 4) begin
        rst = 0;
        model_reset();
      end
    end
    apply_reset();
  endtask

  task automatic test_wrap();
    int wrap_exp[5] = '{1, 2, 3, 0, 1};
    int k;
    apply_reset();
    k = 0;
    for (int c = 0; c < 16; c++) begin
      sv0 = 1; a0 = 1'($urandom); b0 = 1'($urandom); sv1 = 0; rl0 = 1; rl1 = 0;
      if (c % 3 != 0) begin sv0 = 1; end
      #1;
      if (c > 0 && c % 3 == 0) begin
        checks++;
        if (y_s0 !== 2'(wrap_exp[k])) begin
          errors++; $display("FAIL wrap%0d got %0d want %0d", k, y_s0, wrap_exp[k]);
        end
        k++;
      end
      @(posedge clk); #1;
    end
    apply_reset();
  endtask

  task automatic test_random();
    bit pend0, pend1;
    apply_reset();
    pend0 = 0; pend1 = 0;
    for (int c = 0; c < 400; c++) begin
      if (!pend0) begin sv0 = 1'($urandom_range(0, 1)); a0 = 1'($urandom); b0 = 1'($urandom); end
      if (!pend1) begin sv1 = 1'($urandom_range(0, 1)); a1 = 1'($urandom); b1 = 1'($urandom); end
      pend0 = sv0; pend1 = sv1;
      rl0 = ($urandom_range(0, 3) != 0);
      rl1 = ($urandom_range(0, 3) != 0);
      #1; model_cycle();
      checks++;
      if (obs_vec !== exp_vec || obs2_vec !== exp_vec) begin
        errors++; $display("FAIL random c%0d outputs got %b/%b want %b", c, obs_vec, obs2_vec, exp_vec);
      end
      checks++;
      if (s0 !== exp_s0[7:0] || s1 !== exp_s1[7:0] || y_s0 !== exp_s0[1:0] || y_s1 !== exp_s1[1:0]) begin
        errors++; $display("FAIL random c%0d servidas got %0d,%0d/%0d,%0d want %0d,%0d",
                           c, s0, s1, y_s0, y_s1, exp_s0, exp_s1);
      end
      if (exp_vec[5]) pend0 = 0;
      if (exp_vec[4]) pend1 = 0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    zero_inputs();
    model_reset();
    test_reset();
    test_single();
    test_both();
    test_alternate();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
